// File: rtl/speles_pkg.sv
// Shared definitions for the binary guessing game control logic:
// state encoding, datapath widths and the per-level round-time rule.
package speles_pkg;

   localparam int LEVEL_W = 8;
   localparam int TIME_W  = 5;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_PLAY  = 2'b01;
   localparam logic [1:0] ST_CHECK = 2'b10;
   localparam logic [1:0] ST_OVER  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_PLAY  = ST_PLAY,
      S_CHECK = ST_CHECK,
      S_OVER  = ST_OVER
   } state_e;

   // Round length for a level: one second shorter per level, floored at
   // t_min and clamped to what the seconds counter can show.
   function automatic logic [TIME_W-1:0] round_time(input int lvl,
                                                    input int t_init,
                                                    input int t_min);
      int v;
      v = t_init - (lvl - 1);
      if (v < t_min) v = t_min;
      if (v > (1 << TIME_W) - 1) v = (1 << TIME_W) - 1;
      if (v < 0) v = 0;
      return v[TIME_W-1:0];
   endfunction

endpackage

// File: rtl/speles_timer.sv
// Round timer: a prescaler producing one tick per TICK_DIV clocks and a
// seconds down-counter. `expire` flags the tick that takes the count from 1
// to 0, so the FSM can act on it in the same cycle.
module speles_timer
   import speles_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              run,
   output logic [TIME_W-1:0] time_v,
   output logic              expire
);

   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [TIME_W-1:0] r_time;
   logic              w_tick;

   assign w_tick = (r_cnt == CNT_LAST);
   // Not qualified by run: the FSM gates it with its own PLAY state.
   assign expire = w_tick && (r_time == TIME_W'(1));
   assign time_v = r_time;

   // Prescaler and seconds counter; a load restarts the second from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_time <= '0;
      end else if (load) begin
         r_cnt  <= '0;
         r_time <= load_val;
      end else if (run) begin
         if (w_tick) begin
            r_cnt <= '0;
            if (r_time != '0) r_time <= r_time - TIME_W'(1);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/speles_logika.sv
// Top-level control for the guessing game: press detection, game FSM,
// level register and the round timer. Outputs are registered except
// g_enable, which is decoded from the state.
module speles_logika
   import speles_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int TIME_INIT = 30,
   parameter int TIME_MIN  = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       guess_b,
   input  logic       cmp_r,
   input  logic       end_f,
   output logic [0:1] state,
   output logic [0:7] level,
   output logic       time_f,
   output logic [0:4] time_v,
   output logic       g_enable
);

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   state_e             r_state;
   logic [LEVEL_W-1:0] r_level;
   logic               r_time_f;
   logic               r_guess_q;
   logic               r_rst_q;

   logic               w_press;
   logic               w_expire;
   logic               w_timeout;
   logic               w_load;
   logic               w_run;
   logic [TIME_W-1:0]  w_load_val;
   logic [TIME_W-1:0]  w_time_v;
   logic [LEVEL_W-1:0] w_level_inc;

   // r_rst_q masks the first cycle after reset so a button held through
   // reset release is not mistaken for a fresh press.
   assign w_press     = guess_b & ~r_guess_q & ~r_rst_q;
   assign w_timeout   = (r_state == S_PLAY) && w_expire;
   assign w_level_inc = (r_level == LEVEL_MAX) ? r_level : r_level + LEVEL_W'(1);

   // Timer runs only while playing; a press freezes it unless the same
   // tick is the one that expires the round.
   assign w_run = (r_state == S_PLAY) && !end_f && (!w_press || w_expire);

   // Timer reload requests on round start, next level and return to idle.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         S_IDLE: begin
            if (w_press) begin
               w_load     = 1'b1;
               w_load_val = round_time(1, TIME_INIT, TIME_MIN);
            end
         end
         S_CHECK: begin
            if (!end_f && w_press && cmp_r) begin
               w_load     = 1'b1;
               w_load_val = round_time(int'(w_level_inc), TIME_INIT, TIME_MIN);
            end
         end
         S_OVER: begin
            if (w_press) begin
               w_load     = 1'b1;
               w_load_val = '0;
            end
         end
         default: ;
      endcase
   end

   // Game FSM with level register, timeout flag and press edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_level   <= '0;
         r_time_f  <= 1'b0;
         r_guess_q <= 1'b0;
         r_rst_q   <= 1'b1;
      end else begin
         r_guess_q <= guess_b;
         r_rst_q   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_press) begin
                  r_state <= S_PLAY;
                  r_level <= LEVEL_W'(1);
               end
            end
            S_PLAY: begin
               if (end_f) begin
                  r_state <= S_OVER;
               end else if (w_timeout) begin
                  r_state  <= S_OVER;
                  r_time_f <= 1'b1;
               end else if (w_press) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (end_f) begin
                  r_state <= S_OVER;
               end else if (w_press) begin
                  if (cmp_r) begin
                     r_state <= S_PLAY;
                     r_level <= w_level_inc;
                  end else begin
                     r_state <= S_OVER;
                  end
               end
            end
            S_OVER: begin
               if (w_press) begin
                  r_state  <= S_IDLE;
                  r_level  <= '0;
                  r_time_f <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   speles_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (w_load_val),
      .run      (w_run),
      .time_v   (w_time_v),
      .expire   (w_expire)
   );

   assign state    = r_state;
   assign level    = r_level;
   assign time_f   = r_time_f;
   assign time_v   = w_time_v;
   assign g_enable = (r_state == S_PLAY);

endmodule

// File: tb/tb_speles_logika.sv
// Directed bench for speles_logika with TICK_DIV=4, TIME_INIT=3, TIME_MIN=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_speles_logika;

   logic       clk;
   logic       rst;
   logic       guess_b;
   logic       cmp_r;
   logic       end_f;
   logic [0:1] state;
   logic [0:7] level;
   logic       time_f;
   logic [0:4] time_v;
   logic       g_enable;

   int n_cmp;
   int n_err;

   speles_logika #(
      .TICK_DIV  (4),
      .TIME_INIT (3),
      .TIME_MIN  (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .guess_b  (guess_b),
      .cmp_r    (cmp_r),
      .end_f    (end_f),
      .state    (state),
      .level    (level),
      .time_f   (time_f),
      .time_v   (time_v),
      .g_enable (g_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; guess_b = 1'b0; cmp_r = 1'b0; end_f = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One press/release: two rising edges elapse.
   task automatic press_rel();
      guess_b = 1'b1;
      @(negedge clk);
      guess_b = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; guess_b = 1'b1; cmp_r = 1'b0; end_f = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL rst_state: got %b want 00", state); end
      n_cmp++; if (level !== 8'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
      n_cmp++; if (g_enable !== 1'b0) begin n_err++; $display("FAIL rst_genable: got %b want 0", g_enable); end
      n_cmp++; if (time_v !== 5'd0 || time_f !== 1'b0) begin n_err++; $display("FAIL rst_time: got v=%0d f=%b want 0/0", time_v, time_f); end
      guess_b = 1'b0;
      @(negedge clk);
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL rst_release_state: got %b want 00", state); end
      guess_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (state !== 2'b01 || level !== 8'd1) begin n_err++; $display("FAIL rst_repress: got st=%b lvl=%0d want 01/1", state, level); end
      guess_b = 1'b0;
   endtask

   task automatic test_lose();
      do_reset();
      guess_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (state !== 2'b01 || g_enable !== 1'b1) begin n_err++; $display("FAIL lose_play: got st=%b en=%b want 01/1", state, g_enable); end
      n_cmp++; if (level !== 8'd1 || time_v !== 5'd3) begin n_err++; $display("FAIL lose_play_vals: got lvl=%0d t=%0d want 1/3", level, time_v); end
      guess_b = 1'b0;
      @(negedge clk);
      cmp_r = 1'b0;
      guess_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (state !== 2'b10 || g_enable !== 1'b0) begin n_err++; $display("FAIL lose_check: got st=%b en=%b want 10/0", state, g_enable); end
      n_cmp++; if (level !== 8'd1 || time_v !== 5'd3) begin n_err++; $display("FAIL lose_check_vals: got lvl=%0d t=%0d want 1/3", level, time_v); end
      guess_b = 1'b0;
      @(negedge clk);
      guess_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (state !== 2'b11 || level !== 8'd1) begin n_err++; $display("FAIL lose_over: got st=%b lvl=%0d want 11/1", state, level); end
      guess_b = 1'b0;
   endtask

   task automatic test_win();
      do_reset();
      press_rel();
      press_rel();
      cmp_r = 1'b1;
      guess_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (state !== 2'b01 || level !== 8'd2 || time_v !== 5'd2) begin n_err++; $display("FAIL win_next: got st=%b lvl=%0d t=%0d want 01/2/2", state, level, time_v); end
      repeat (4) @(negedge clk);
      n_cmp++; if (state !== 2'b01 || level !== 8'd2) begin n_err++; $display("FAIL win_hold: got st=%b lvl=%0d want 01/2", state, level); end
      guess_b = 1'b0;
      cmp_r = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      guess_b = 1'b1;
      @(negedge clk);
      guess_b = 1'b0;
      n_cmp++; if (time_v !== 5'd3) begin n_err++; $display("FAIL to_t0: got %0d want 3", time_v); end
      repeat (3) @(negedge clk);
      n_cmp++; if (time_v !== 5'd3) begin n_err++; $display("FAIL to_t3: got %0d want 3", time_v); end
      @(negedge clk);
      n_cmp++; if (time_v !== 5'd2) begin n_err++; $display("FAIL to_t4: got %0d want 2", time_v); end
      repeat (4) @(negedge clk);
      n_cmp++; if (time_v !== 5'd1 || state !== 2'b01) begin n_err++; $display("FAIL to_t8: got t=%0d st=%b want 1/01", time_v, state); end
      repeat (3) @(negedge clk);
      n_cmp++; if (time_v !== 5'd1 || time_f !== 1'b0) begin n_err++; $display("FAIL to_t11: got t=%0d f=%b want 1/0", time_v, time_f); end
      @(negedge clk);
      n_cmp++; if (time_v !== 5'd0 || time_f !== 1'b1 || state !== 2'b11) begin n_err++; $display("FAIL to_t12: got t=%0d f=%b st=%b want 0/1/11", time_v, time_f, state); end
      press_rel();
      n_cmp++; if (state !== 2'b00 || time_f !== 1'b0 || level !== 8'd0 || time_v !== 5'd0) begin n_err++; $display("FAIL to_idle: got st=%b f=%b lvl=%0d t=%0d want 00/0/0/0", state, time_f, level, time_v); end
   endtask

   task automatic test_end_f();
      do_reset();
      end_f = 1'b1;
      repeat (2) @(negedge clk);
      end_f = 1'b0;
      n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL endf_idle: got %b want 00", state); end
      press_rel();
      end_f = 1'b1;
      @(negedge clk);
      end_f = 1'b0;
      n_cmp++; if (state !== 2'b11 || level !== 8'd1) begin n_err++; $display("FAIL endf_play: got st=%b lvl=%0d want 11/1", state, level); end
   endtask

   task automatic test_tick_press();
      do_reset();
      guess_b = 1'b1;
      @(negedge clk);
      guess_b = 1'b0;
      repeat (3) @(negedge clk);
      guess_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (state !== 2'b10 || time_v !== 5'd3) begin n_err++; $display("FAIL tp_check: got st=%b t=%0d want 10/3", state, time_v); end
      guess_b = 1'b0;
      @(negedge clk);
      cmp_r = 1'b1;
      guess_b = 1'b1;
      @(negedge clk);
      guess_b = 1'b0;
      cmp_r = 1'b0;
      n_cmp++; if (level !== 8'd2 || time_v !== 5'd2) begin n_err++; $display("FAIL tp_lvl2: got lvl=%0d t=%0d want 2/2", level, time_v); end
      repeat (4) @(negedge clk);
      n_cmp++; if (time_v !== 5'd1) begin n_err++; $display("FAIL tp_dec: got %0d want 1", time_v); end
      repeat (3) @(negedge clk);
      guess_b = 1'b1;
      @(negedge clk);
      guess_b = 1'b0;
      n_cmp++; if (state !== 2'b11 || time_f !== 1'b1 || time_v !== 5'd0) begin n_err++; $display("FAIL tp_expire: got st=%b f=%b t=%0d want 11/1/0", state, time_f, time_v); end
   endtask

   task automatic test_saturation();
      do_reset();
      press_rel();
      cmp_r = 1'b1;
      for (int i = 0; i < 254; i++) begin
         press_rel();
         press_rel();
      end
      n_cmp++; if (level !== 8'd255 || time_v !== 5'd2 || state !== 2'b01) begin n_err++; $display("FAIL sat_255: got lvl=%0d t=%0d st=%b want 255/2/01", level, time_v, state); end
      press_rel();
      press_rel();
      n_cmp++; if (level !== 8'd255 || time_v !== 5'd2) begin n_err++; $display("FAIL sat_hold: got lvl=%0d t=%0d want 255/2", level, time_v); end
      cmp_r = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; guess_b = 1'b0; cmp_r = 1'b0; end_f = 1'b0;
      test_reset();
      test_lose();
      test_win();
      test_timeout();
      test_end_f();
      test_tick_press();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
